// File: rtl/column_frame_ctrl.sv
// Double-buffered column-parameter store with a vblank-aligned bank swap.
// Avalon writes fill the back bank; the pixel reader prefetches the front bank.
module column_frame_ctrl #(
  parameter int unsigned NCOLS    = 640,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CTRL_ADR = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [DATA_W-1:0] col_data,
  output logic              col_valid,
  output logic              frame_sync
);

  localparam logic [ADDR_W-1:0] NColsAddr = ADDR_W'(NCOLS);
  localparam logic [ADDR_W-1:0] CtrlAddr  = ADDR_W'(CTRL_ADR);
  localparam logic [9:0]        NColsPix  = 10'(NCOLS);
  localparam logic [10:0]       HLast     = 11'd1599;
  localparam logic [9:0]        VLast     = 10'd524;
  localparam logic [9:0]        VVisible  = 10'd480;

  typedef enum logic [0:0] {StShow, StArmed} state_e;

  state_e            state_q, state_d;
  logic              front_sel_q;
  logic [7:0]        frame_cnt_q;
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] col_data_q;
  logic              col_valid_q;
  logic              frame_sync_q;

  logic [DATA_W-1:0] bank0 [NCOLS];
  logic [DATA_W-1:0] bank1 [NCOLS];

  logic       entry_wr;
  logic       swap_req;
  logic       status_rd;
  logic       vblank_start;
  logic       swap_evt;
  logic [9:0] c_next;
  logic [9:0] v_next;

  assign entry_wr     = chipselect && write && (address < NColsAddr);
  assign swap_req     = chipselect && write && (address == CtrlAddr) && writedata[0];
  assign status_rd    = chipselect && read && (address == CtrlAddr);
  assign vblank_start = (vcount == VVisible) && (hcount == 11'd0);

  // Prefetch target: the column shown on the next two pixel clocks, wrapping with the line.
  always_comb begin
    c_next = hcount[10:1] + 10'd1;
    v_next = vcount;
    if (hcount == HLast) begin
      c_next = '0;
      v_next = (vcount == VLast) ? '0 : vcount + 10'd1;
    end
  end

  // A request on the swap clock re-arms immediately for the following vblank.
  always_comb begin
    state_d  = state_q;
    swap_evt = 1'b0;
    unique case (state_q)
      StShow: begin
        if (swap_req) state_d = StArmed;
      end
      StArmed: begin
        swap_evt = vblank_start;
        if (swap_evt && !swap_req) state_d = StShow;
      end
      default: state_d = StShow;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StShow;
      front_sel_q  <= 1'b0;
      frame_cnt_q  <= 8'd0;
      readdata_q   <= '0;
      col_data_q   <= '0;
      col_valid_q  <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_sync_q <= swap_evt;
      if (swap_evt) begin
        front_sel_q <= ~front_sel_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      if (chipselect && read) begin
        readdata_q <= status_rd ?
            DATA_W'({frame_cnt_q, 6'b0, front_sel_q, state_q == StArmed}) : '0;
      end
      if (hcount[0]) begin
        if (c_next < NColsPix) begin
          col_data_q <= front_sel_q ? bank1[c_next] : bank0[c_next];
        end else begin
          col_data_q <= '0;
        end
        col_valid_q <= (c_next < NColsPix) && (v_next < VVisible);
      end
    end
  end

  // Writes always target the pre-swap back bank, even on the swap clock itself.
  always_ff @(posedge clk) begin
    if (entry_wr) begin
      if (front_sel_q) bank0[address] <= writedata;
      else             bank1[address] <= writedata;
    end
  end

  assign readdata   = readdata_q;
  assign col_data   = col_data_q;
  assign col_valid  = col_valid_q;
  assign frame_sync = frame_sync_q;

endmodule
